// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command path: ASCII constants, command and
// error encodings, and the parser state enumeration.
package uart_cmd_pkg;

    localparam logic [7:0] AsciiMoveUpper  = 8'h4D;  // 'M'
    localparam logic [7:0] AsciiMoveLower  = 8'h6D;  // 'm'
    localparam logic [7:0] AsciiNewUpper   = 8'h4E;  // 'N'
    localparam logic [7:0] AsciiNewLower   = 8'h6E;  // 'n'
    localparam logic [7:0] AsciiQueryUpper = 8'h51;  // 'Q'
    localparam logic [7:0] AsciiQueryLower = 8'h71;  // 'q'
    localparam logic [7:0] AsciiDigitLo    = 8'h30;  // '0'
    localparam logic [7:0] AsciiDigitHi    = 8'h32;  // '2'
    localparam logic [7:0] AsciiCr         = 8'h0D;
    localparam logic [7:0] AsciiLf         = 8'h0A;
    localparam logic [7:0] AsciiSpace      = 8'h20;

    typedef enum logic [1:0] {
        OpMove    = 2'b00,
        OpNewGame = 2'b01,
        OpQuery   = 2'b10
    } cmd_op_e;

    typedef enum logic [1:0] {
        ErrOverrun = 2'b00,
        ErrBadChar = 2'b01,
        ErrBadTerm = 2'b10,
        ErrTimeout = 2'b11
    } err_code_e;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StGetRow  = 2'b01,
        StGetCol  = 2'b10,
        StGetTerm = 2'b11
    } parser_state_e;

endpackage

// File: rtl/cmd_char_decode.sv
// Combinational classifier for one received byte of a command frame.
module cmd_char_decode
    import uart_cmd_pkg::*;
(
    input  logic [7:0] rx_byte,
    output logic       is_move,
    output logic       is_new,
    output logic       is_query,
    output logic       is_digit,
    output logic [1:0] digit_val,
    output logic       is_term,
    output logic       is_blank
);

    always_comb begin
        is_move   = (rx_byte == AsciiMoveUpper) || (rx_byte == AsciiMoveLower);
        is_new    = (rx_byte == AsciiNewUpper) || (rx_byte == AsciiNewLower);
        is_query  = (rx_byte == AsciiQueryUpper) || (rx_byte == AsciiQueryLower);
        is_digit  = (rx_byte >= AsciiDigitLo) && (rx_byte <= AsciiDigitHi);
        // '0'..'2' are 0x30..0x32, so the low bits are the value
        digit_val = rx_byte[1:0];
        is_term   = (rx_byte == AsciiCr) || (rx_byte == AsciiLf);
        is_blank  = is_term || (rx_byte == AsciiSpace);
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles ASCII command frames from the UART byte strobe and hands decoded
// commands to the game controller over valid/ready, reporting dropped frames.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned TO_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_op,
    output logic [1:0] cmd_row,
    output logic [1:0] cmd_col,
    output logic       err_pulse,
    output logic [1:0] err_code
);

    localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT_CYCLES - 1);

    parser_state_e   state_q, state_d;
    cmd_op_e         op_q, op_d;
    logic [1:0]      row_q, row_d;
    logic [1:0]      col_q, col_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    logic            cmd_valid_q, cmd_valid_d;
    cmd_op_e         cmd_op_q, cmd_op_d;
    logic [1:0]      cmd_row_q, cmd_row_d;
    logic [1:0]      cmd_col_q, cmd_col_d;
    logic            err_pulse_q, err_pulse_d;
    err_code_e       err_code_q, err_code_d;

    logic            is_move, is_new, is_query, is_digit, is_term, is_blank;
    logic [1:0]      digit_val;
    logic            timeout_hit;
    logic            frame_done;

    cmd_char_decode u_decode (
        .rx_byte  (rx_data),
        .is_move  (is_move),
        .is_new   (is_new),
        .is_query (is_query),
        .is_digit (is_digit),
        .digit_val(digit_val),
        .is_term  (is_term),
        .is_blank (is_blank)
    );

    // A byte arriving on the threshold clock takes priority over the timeout.
    assign timeout_hit = (state_q != StIdle) && !rx_valid && (cnt_q == ToLast);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        row_d       = row_q;
        col_d       = col_q;
        frame_done  = 1'b0;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;

        if (rx_valid) begin
            case (state_q)
                StIdle: begin
                    if (is_move) begin
                        op_d    = OpMove;
                        state_d = StGetRow;
                    end else if (is_new || is_query) begin
                        op_d    = is_new ? OpNewGame : OpQuery;
                        row_d   = 2'd0;
                        col_d   = 2'd0;
                        state_d = StGetTerm;
                    end else if (!is_blank) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = ErrBadChar;
                    end
                end
                StGetRow: begin
                    if (is_digit) begin
                        row_d   = digit_val;
                        state_d = StGetCol;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_code_d  = ErrBadChar;
                        state_d     = StIdle;
                    end
                end
                StGetCol: begin
                    if (is_digit) begin
                        col_d   = digit_val;
                        state_d = StGetTerm;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_code_d  = ErrBadChar;
                        state_d     = StIdle;
                    end
                end
                StGetTerm: begin
                    if (is_term) begin
                        frame_done = 1'b1;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_code_d  = ErrBadTerm;
                    end
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end else if (timeout_hit) begin
            err_pulse_d = 1'b1;
            err_code_d  = ErrTimeout;
            state_d     = StIdle;
        end
    end

    always_comb begin
        cnt_d = cnt_q + TO_W'(1);
        if (rx_valid || (state_q == StIdle) || timeout_hit) begin
            cnt_d = '0;
        end
    end

    // Output slot: a completed frame loads only if the slot is free this cycle.
    always_comb begin
        cmd_valid_d = cmd_valid_q && !cmd_ready;
        cmd_op_d    = cmd_op_q;
        cmd_row_d   = cmd_row_q;
        cmd_col_d   = cmd_col_q;
        if (frame_done) begin
            if (!cmd_valid_q || cmd_ready) begin
                cmd_valid_d = 1'b1;
                cmd_op_d    = op_q;
                cmd_row_d   = row_q;
                cmd_col_d   = col_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            op_q        <= OpMove;
            row_q       <= 2'd0;
            col_q       <= 2'd0;
            cnt_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= OpMove;
            cmd_row_q   <= 2'd0;
            cmd_col_q   <= 2'd0;
            err_pulse_q <= 1'b0;
            err_code_q  <= ErrOverrun;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            row_q       <= row_d;
            col_q       <= col_d;
            cnt_q       <= cnt_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_op_q    <= cmd_op_d;
            cmd_row_q   <= cmd_row_d;
            cmd_col_q   <= cmd_col_d;
            if (frame_done && cmd_valid_q && !cmd_ready) begin
                err_pulse_q <= 1'b1;
                err_code_q  <= ErrOverrun;
            end else begin
                err_pulse_q <= err_pulse_d;
                err_code_q  <= err_code_d;
            end
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_op    = cmd_op_q;
    assign cmd_row   = cmd_row_q;
    assign cmd_col   = cmd_col_q;
    assign err_pulse = err_pulse_q;
    assign err_code  = err_code_q;

endmodule
